// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Every 3 binary bits need at most one decimal digit, so this covers the full input range.
    function automatic int int_digits(input int bin_w);
        return (bin_w + 2) / 3;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus between a requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift/add-3 iteration per input bit.
// Build option: define BIN2BCD_SATURATE_EN to clamp bcd_out to all nines on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int INT_DIGITS = int_digits(BIN_W);
    localparam int ACC_W      = 4 * INT_DIGITS;
    localparam int CNT_W      = $clog2(BIN_W + 1);
    localparam int OUT_DIGITS = (DIGITS < INT_DIGITS) ? DIGITS : INT_DIGITS;

`ifdef BIN2BCD_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    state_t                        state;
    logic [BIN_W-1:0]              sr;
    logic [INT_DIGITS-1:0][3:0]    acc;
    logic [INT_DIGITS-1:0][3:0]    acc_adj;
    logic [CNT_W-1:0]              cnt;
    logic                          busy_q;
    logic                          done_q;
    logic                          ovf_q;
    logic [DIGITS-1:0][3:0]        bcd_q;

    logic [DIGITS-1:0][3:0]        bcd_nxt;
    logic                          ovf_nxt;
    logic [ACC_W+BIN_W-1:0]        shifted;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.din(acc[g]), .dout(acc_adj[g]));
    end

    assign shifted = {acc_adj, sr} << 1;

    // Result formatting from the finished accumulator, consumed in DONE.
    always_comb begin
        bcd_nxt = '0;
        ovf_nxt = 1'b0;
        for (int i = 0; i < OUT_DIGITS; i++)
            bcd_nxt[i] = acc[i];
        for (int i = OUT_DIGITS; i < INT_DIGITS; i++)
            if (acc[i] != 4'd0) ovf_nxt = 1'b1;
        if (SATURATE && ovf_nxt)
            bcd_nxt = {DIGITS{BCD_NINE}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            bcd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr     <= bus.bin_in;
                        acc    <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    {acc, sr} <= shifted;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    bcd_q  <= bcd_nxt;
                    ovf_q  <= ovf_nxt;
                    done_q <= 1'b1;
                    // Back-to-back capture keeps the period at BIN_W+1 with no gap cycle.
                    if (bus.start) begin
                        sr     <= bus.bin_in;
                        acc    <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with default parameters.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(4)) bus ();

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] val, input logic [15:0] exp_bcd,
                       input logic exp_ovf, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = val;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin_in = 16'hBEEF;
        lat = -1;
        bcnt = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) lat = k;
        end
        chk({tag, " latency"}, lat, 17);
        chk({tag, " busy_cycles"}, bcnt, 16);
        chk({tag, " bcd_out"}, {16'h0, bus.bcd_out}, {16'h0, exp_bcd});
        chk({tag, " overflow"}, {31'h0, bus.overflow}, {31'h0, exp_ovf});
        @(negedge clk);
        chk({tag, " done_single"}, {31'h0, bus.done}, 32'h0);
    endtask

    initial begin
        int ndone;
        logic [15:0] first_bcd;
        int dk[$];
        logic [15:0] dv[$];
        logic [15:0] exp_sat;

        bus.start = 1'b0;
        bus.bin_in = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'h0, bus.busy}, 32'h0);
        chk("rst done", {31'h0, bus.done}, 32'h0);
        chk("rst bcd_out", {16'h0, bus.bcd_out}, 32'h0);
        chk("rst overflow", {31'h0, bus.overflow}, 32'h0);
        rst_n = 1'b1;

        run(16'd1234, 16'h1234, 1'b0, "v1234");
        run(16'd0,    16'h0000, 1'b0, "v0");
        run(16'd9999, 16'h9999, 1'b0, "v9999");

        // start pulsed mid-conversion must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 16'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        first_bcd = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (ndone == 0) first_bcd = bus.bcd_out;
                ndone++;
            end
        end
        chk("ignore done_count", ndone, 1);
        chk("ignore bcd_out", {16'h0, first_bcd}, 32'h1234);

        // start held high: results 0,1,2 every 17 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 16'd0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dk.push_back(k);
                dv.push_back(bus.bcd_out);
            end
            if (k == 0)  bus.bin_in = 16'd1;
            if (k == 17) bus.bin_in = 16'd2;
            if (k == 34) bus.start = 1'b0;
        end
        chk("b2b done_count", dk.size(), 3);
        if (dk.size() == 3) begin
            chk("b2b k0", dk[0], 17);
            chk("b2b k1", dk[1], 34);
            chk("b2b k2", dk[2], 51);
            chk("b2b v0", {16'h0, dv[0]}, 32'h0000);
            chk("b2b v1", {16'h0, dv[1]}, 32'h0001);
            chk("b2b v2", {16'h0, dv[2]}, 32'h0002);
        end

`ifdef BIN2BCD_SATURATE_EN
        exp_sat = 16'h9999;
`else
        exp_sat = 16'h5535;
`endif
        run(16'd65535, exp_sat, 1'b1, "v65535");

        // reset in the middle of converting 4321
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin_in = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst busy_before", {31'h0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'h0, bus.busy}, 32'h0);
        chk("midrst done", {31'h0, bus.done}, 32'h0);
        chk("midrst bcd_out", {16'h0, bus.bcd_out}, 32'h0);
        chk("midrst overflow", {31'h0, bus.overflow}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        run(16'd42, 16'h0042, 1'b0, "v42");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
